// File: rtl/multi_debounce.sv
// N-channel push-button debouncer: 2-FF synchroniser, stability counter, and
// registered press / release (rel) / long-press hold pulses per channel.
module multi_debounce #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 2500000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] but,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    // 'release' is a reserved word in SystemVerilog, so the release pulse is named rel
    output logic [N_CH-1:0] rel,
    output logic [N_CH-1:0] hold
);

    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] R_LAST = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic [N_CH-1:0] b_in;
    assign b_in = (ACTIVE_LOW != 0) ? ~but : but;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic          s1_reg;
            logic          s2_reg;
            logic [DW-1:0] cnt_reg;
            logic [HW-1:0] hcnt_reg;
            logic          rep_reg;
            logic          level_reg;
            logic          press_reg;
            logic          rel_reg;
            logic          hold_reg;
            logic          commit;

            // The mismatch run has reached its required length at this edge
            assign commit = (s2_reg != level_reg) && (cnt_reg == D_LAST);

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_reg    <= 1'b0;
                    s2_reg    <= 1'b0;
                    cnt_reg   <= '0;
                    hcnt_reg  <= '0;
                    rep_reg   <= 1'b0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                    rel_reg   <= 1'b0;
                    hold_reg  <= 1'b0;
                end else begin
                    s1_reg    <= b_in[gi];
                    s2_reg    <= s1_reg;
                    press_reg <= 1'b0;
                    rel_reg   <= 1'b0;
                    hold_reg  <= 1'b0;

                    if (s2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (!commit) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else begin
                        cnt_reg   <= '0;
                        level_reg <= s2_reg;
                        press_reg <= s2_reg;
                        rel_reg   <= ~s2_reg;
                    end

                    // rep_reg marks that the first hold pulse has been issued
                    if (commit || !level_reg) begin
                        hcnt_reg <= '0;
                        rep_reg  <= 1'b0;
                    end else if (!rep_reg) begin
                        if (hcnt_reg == H_LAST) begin
                            hold_reg <= 1'b1;
                            hcnt_reg <= '0;
                            rep_reg  <= 1'b1;
                        end else begin
                            hcnt_reg <= hcnt_reg + 1'b1;
                        end
                    end else if (REPEAT_CYCLES != 0) begin
                        if (hcnt_reg == R_LAST) begin
                            hold_reg <= 1'b1;
                            hcnt_reg <= '0;
                        end else begin
                            hcnt_reg <= hcnt_reg + 1'b1;
                        end
                    end
                end
            end

            assign level[gi] = level_reg;
            assign press[gi] = press_reg;
            assign rel[gi]   = rel_reg;
            assign hold[gi]  = hold_reg;
        end
    endgenerate

endmodule
